// File: rtl/msu_pkg.sv
// MSU stream framing helpers and the job-driver state encoding.
package msu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_RECV,
    ST_DONE
  } drv_state_e;

  function automatic int unsigned msu_in_count(input int unsigned axi_len,
                                               input int unsigned t_len,
                                               input int unsigned sq_in_bits);
    return (2 * t_len + sq_in_bits + axi_len - 1) / axi_len;
  endfunction

  function automatic int unsigned msu_out_count(input int unsigned axi_len,
                                                input int unsigned t_len,
                                                input int unsigned sq_out_bits);
    return (t_len + sq_out_bits + axi_len - 1) / axi_len;
  endfunction

endpackage

// File: rtl/redun_mont_pkg.sv
// Redundant-Montgomery datapath widths shared by the MSU and its host-side driver.
package redun_mont_pkg;
  localparam int DAT_BITS = 1024;
  localparam int TOT_BITS = 1088;
endpackage

// File: rtl/msu_beat_shifter.sv
// Parallel-load register that shifts down by STEP bits, inserting i_shift_in at the top.
module msu_beat_shifter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned STEP  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic [STEP-1:0]  i_shift_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {i_shift_in, r_q[WIDTH-1:STEP]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/msu_job_driver.sv
// Host-side MSU job initiator: serialises a job onto m_axis and collects the s_axis response.
// Optional RECV watchdog enabled by defining MSU_DRV_TIMEOUT_EN.
module msu_job_driver
  import msu_pkg::*;
#(
  parameter int unsigned AXI_LEN        = 32,
  parameter int unsigned T_LEN          = 64,
  parameter int unsigned SQ_IN_BITS     = redun_mont_pkg::DAT_BITS,
  parameter int unsigned SQ_OUT_BITS    = redun_mont_pkg::TOT_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [T_LEN-1:0]       job_t_start,
  input  logic [T_LEN-1:0]       job_t_final,
  input  logic [SQ_IN_BITS-1:0]  job_sq_in,
  output logic                   ap_start,
  input  logic                   ap_done,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXI_LEN-1:0]     m_axis_tdata,
  output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [AXI_LEN-1:0]     s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [T_LEN-1:0]       res_t_current,
  output logic [SQ_OUT_BITS-1:0] res_sq_out,
  output logic                   res_error,
  output logic                   res_timeout
);

  localparam int unsigned IN_COUNT  = msu_in_count(AXI_LEN, T_LEN, SQ_IN_BITS);
  localparam int unsigned OUT_COUNT = msu_out_count(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int unsigned TX_W      = IN_COUNT * AXI_LEN;
  localparam int unsigned RX_W      = OUT_COUNT * AXI_LEN;
  localparam int unsigned TX_CW     = $clog2(IN_COUNT + 1);
  localparam int unsigned RX_CW     = $clog2(OUT_COUNT + 1);

  drv_state_e        r_state, w_state_nxt;
  logic              r_rdy_arm;
  logic [TX_CW-1:0]  r_tx_cnt;
  logic [RX_CW-1:0]  r_rx_cnt;
  logic              r_err, w_err_nxt;
  logic              w_tx_hs, w_rx_hs, w_tx_load, w_rx_last_beat;
  logic [TX_W-1:0]   w_job_word, w_tx_q;
  logic [RX_W-1:0]   w_rx_q;
  logic              w_marker, w_wd_tmo;
  logic              w_unused;

  assign w_job_word     = TX_W'({job_sq_in, job_t_final, job_t_start});
  assign w_tx_hs        = m_axis_tvalid && m_axis_tready;
  assign w_rx_hs        = s_axis_tvalid && s_axis_tready;
  assign w_tx_load      = job_valid && job_ready;
  assign w_rx_last_beat = (r_rx_cnt == RX_CW'(OUT_COUNT - 1));

  msu_beat_shifter #(.WIDTH(TX_W), .STEP(AXI_LEN)) u_tx_shift (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_load      (w_tx_load),
    .i_load_data (w_job_word),
    .i_shift     (w_tx_hs),
    .i_shift_in  ('0),
    .o_q         (w_tx_q)
  );

  msu_beat_shifter #(.WIDTH(RX_W), .STEP(AXI_LEN)) u_rx_shift (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_hs),
    .i_shift_in  (s_axis_tdata),
    .o_q         (w_rx_q)
  );

`ifdef MSU_DRV_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_tmo, w_wd_tmo_nxt, w_wd_hit;

  assign w_wd_hit = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_wd_tmo = r_wd_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
      r_wd_tmo <= 1'b0;
    end else begin
      r_wd_tmo <= w_wd_tmo_nxt;
      if (r_state != ST_RECV || w_rx_hs) r_wd_cnt <= '0;
      else                               r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_rdy_arm <= 1'b0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rdy_arm <= 1'b1;
      r_err     <= w_err_nxt;
      if (r_state == ST_IDLE) r_tx_cnt <= '0;
      else if (w_tx_hs)       r_tx_cnt <= r_tx_cnt + 1'b1;
      if (r_state == ST_IDLE) r_rx_cnt <= '0;
      else if (w_rx_hs)       r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_err_nxt     = r_err;
`ifdef MSU_DRV_TIMEOUT_EN
    w_wd_tmo_nxt  = r_wd_tmo;
`endif
    job_ready     = 1'b0;
    ap_start      = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    res_valid     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Ready is held off for the first cycle out of reset.
        job_ready = r_rdy_arm;
        w_err_nxt = 1'b0;
`ifdef MSU_DRV_TIMEOUT_EN
        w_wd_tmo_nxt = 1'b0;
`endif
        if (job_valid && r_rdy_arm) w_state_nxt = ST_START;
      end
      ST_START: begin
        ap_start    = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (r_tx_cnt == TX_CW'(IN_COUNT - 1));
        if (w_tx_hs && m_axis_tlast) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        s_axis_tready = 1'b1;
        // Frame ends at tlast or at the expected final beat, whichever comes first.
        if (w_rx_hs) begin
          if (s_axis_tlast || w_rx_last_beat) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = !(s_axis_tlast && w_rx_last_beat);
          end
        end
`ifdef MSU_DRV_TIMEOUT_EN
        else if (w_wd_hit) begin
          w_state_nxt  = ST_DONE;
          w_wd_tmo_nxt = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b0;
`ifdef MSU_DRV_TIMEOUT_EN
          w_wd_tmo_nxt = 1'b0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign m_axis_tdata  = w_tx_q[AXI_LEN-1:0];
  assign m_axis_tkeep  = '1;
  assign res_t_current = w_rx_q[T_LEN-1:0];
  assign res_sq_out    = w_rx_q[T_LEN +: SQ_OUT_BITS];
  assign res_error     = r_err;
  assign w_marker      = (r_state == ST_DONE) && (res_t_current == '1);
  assign res_timeout   = w_marker || w_wd_tmo;

  assign w_unused = ^{ap_done, w_tx_q, w_rx_q, TIMEOUT_CYCLES};

endmodule
